// File: rtl/timing_loop_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : timing_loop_ctrl
// Purpose  : Symbol-timing loop sequencer: fill, acquisition/tracking lock
//            detection, symbol strobe generation and one-sample slip control.
// Revision : 1.0 - initial release
// ============================================================================
module timing_loop_ctrl #(
  parameter int OSF        = 20,
  parameter int WE         = 18,
  parameter int FILL_LEN   = 24,
  parameter int LOCK_THR   = 2048,
  parameter int LOCK_CNT   = 32,
  parameter int UNLOCK_CNT = 8
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 en_i,
  input  logic                 iq_val,
  input  logic signed [WE-1:0] e_in_i,
  input  logic                 e_valid_i,
  input  logic [1:0]           adj_i,
  input  logic                 adj_val_i,
  output logic                 sym_valid_o,
  output logic                 gain_sel_o,
  output logic [1:0]           state_o,
  output logic                 locked_o,
  output logic                 slip_ovf_o
);

  localparam int PW = $clog2(OSF + 1);
  localparam int FW = $clog2(FILL_LEN + 1);
  localparam int GW = $clog2(LOCK_CNT + 1);
  localparam int BW = $clog2(UNLOCK_CNT + 1);

  localparam logic [PW-1:0] c_term_nom = PW'(OSF - 1);
  localparam logic [PW-1:0] c_term_adv = PW'(OSF - 2);
  localparam logic [PW-1:0] c_term_ret = PW'(OSF);
  localparam logic [FW-1:0] c_fill_last = FW'(FILL_LEN - 1);
  localparam logic [GW-1:0] c_lock_cnt = GW'(LOCK_CNT);
  localparam logic [BW-1:0] c_unlock_cnt = BW'(UNLOCK_CNT);
  localparam logic [WE:0]   c_lock_thr = (WE+1)'(LOCK_THR);
  localparam logic [WE-1:0] c_e_max = {1'b0, {(WE-1){1'b1}}};
  localparam logic [WE-1:0] c_e_min = {1'b1, {(WE-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_FILL  = 2'b01,
    S_ACQ   = 2'b10,
    S_TRACK = 2'b11
  } state_t;

  state_t        r_state, w_state;
  logic [FW-1:0] r_fill_cnt, w_fill_cnt;
  logic [PW-1:0] r_phase_cnt, w_phase_cnt;
  logic [GW-1:0] r_good_cnt, w_good_cnt, w_good_inc;
  logic [BW-1:0] r_bad_cnt, w_bad_cnt, w_bad_inc;
  logic          r_adj_pend, w_adj_pend;
  logic          r_adj_ret, w_adj_ret;
  logic          r_slip_ovf, w_slip_ovf;
  logic          r_sym_valid, w_sym_valid;
  logic [WE-1:0] w_e_abs;
  logic          w_good;
  logic [PW-1:0] w_term;
  logic          w_wrap, w_consume, w_adj_req;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_fill_cnt  <= '0;
      r_phase_cnt <= '0;
      r_good_cnt  <= '0;
      r_bad_cnt   <= '0;
      r_adj_pend  <= 1'b0;
      r_adj_ret   <= 1'b0;
      r_slip_ovf  <= 1'b0;
      r_sym_valid <= 1'b0;
    end else begin
      r_state     <= w_state;
      r_fill_cnt  <= w_fill_cnt;
      r_phase_cnt <= w_phase_cnt;
      r_good_cnt  <= w_good_cnt;
      r_bad_cnt   <= w_bad_cnt;
      r_adj_pend  <= w_adj_pend;
      r_adj_ret   <= w_adj_ret;
      r_slip_ovf  <= w_slip_ovf;
      r_sym_valid <= w_sym_valid;
    end
  end

  // Most-negative error has no positive twin; clamp it to the largest magnitude.
  always_comb begin
    w_e_abs = $unsigned(e_in_i);
    if (e_in_i[WE-1]) begin
      if ($unsigned(e_in_i) == c_e_min) w_e_abs = c_e_max;
      else                              w_e_abs = $unsigned(-e_in_i);
    end
  end

  assign w_good     = ({1'b0, w_e_abs} < c_lock_thr);
  assign w_good_inc = r_good_cnt + 1'b1;
  assign w_bad_inc  = r_bad_cnt + 1'b1;
  assign w_adj_req  = adj_val_i && adj_i[0];

  always_comb begin
    w_term = c_term_nom;
    if (r_adj_pend) w_term = r_adj_ret ? c_term_ret : c_term_adv;
  end

  // An advance that lands after phase OSF-2 cannot shorten this period, so the
  // nominal wrap is taken and the request stays pending for the next one.
  assign w_wrap    = iq_val && (r_phase_cnt >= w_term);
  assign w_consume = w_wrap && r_adj_pend && (r_phase_cnt == w_term);

  always_comb begin
    w_state     = r_state;
    w_fill_cnt  = r_fill_cnt;
    w_phase_cnt = r_phase_cnt;
    w_good_cnt  = r_good_cnt;
    w_bad_cnt   = r_bad_cnt;
    w_adj_pend  = r_adj_pend;
    w_adj_ret   = r_adj_ret;
    w_slip_ovf  = r_slip_ovf;
    case (r_state)
      S_IDLE: begin
        if (en_i) begin
          w_state    = S_FILL;
          w_fill_cnt = '0;
          w_slip_ovf = 1'b0;
        end
      end
      S_FILL: begin
        if (iq_val) begin
          if (r_fill_cnt == c_fill_last) begin
            w_state     = S_ACQ;
            w_phase_cnt = '0;
          end else begin
            w_fill_cnt = r_fill_cnt + 1'b1;
          end
        end
      end
      default: begin
        if (iq_val) w_phase_cnt = w_wrap ? '0 : r_phase_cnt + 1'b1;
        if (w_consume) w_adj_pend = 1'b0;
        if (w_adj_req) begin
          if (!r_adj_pend || w_consume) begin
            w_adj_pend = 1'b1;
            w_adj_ret  = adj_i[1];
          end else begin
            w_slip_ovf = 1'b1;
          end
        end
        if (e_valid_i) begin
          if (w_good) begin
            if (r_state == S_ACQ && w_good_inc == c_lock_cnt) begin
              w_state    = S_TRACK;
              w_good_cnt = '0;
              w_bad_cnt  = '0;
            end else begin
              if (r_good_cnt != c_lock_cnt) w_good_cnt = w_good_inc;
              w_bad_cnt = '0;
            end
          end else begin
            if (r_state == S_TRACK && w_bad_inc == c_unlock_cnt) begin
              w_state    = S_ACQ;
              w_good_cnt = '0;
              w_bad_cnt  = '0;
            end else begin
              if (r_bad_cnt != c_unlock_cnt) w_bad_cnt = w_bad_inc;
              w_good_cnt = '0;
            end
          end
        end
      end
    endcase
    if (!en_i) begin
      w_state     = S_IDLE;
      w_phase_cnt = '0;
      w_good_cnt  = '0;
      w_bad_cnt   = '0;
      w_adj_pend  = 1'b0;
      w_adj_ret   = 1'b0;
    end
    w_sym_valid = (w_state == S_ACQ || w_state == S_TRACK) && (w_phase_cnt == '0);
  end

  assign sym_valid_o = r_sym_valid;
  assign state_o     = r_state;
  assign gain_sel_o  = (r_state == S_TRACK);
  assign locked_o    = (r_state == S_TRACK);
  assign slip_ovf_o  = r_slip_ovf;

endmodule
`default_nettype wire

// File: doc/timing_loop_ctrl.md
TIMING_LOOP_CTRL -- requirements
Module: timing_loop_ctrl

Interface
REQ-001 SHALL have parameters: OSF, 20, samples/symbol (min 4); WE, 18, error width; FILL_LEN, 24, samples discarded after enable; LOCK_THR, 2048, unsigned lock threshold on |error|; LOCK_CNT, 32, consecutive good symbols to lock; UNLOCK_CNT, 8, consecutive bad symbols to unlock.
REQ-002 SHALL have ports: clk  in  1  sole clock, rising edge.
REQ-003 SHALL have ports: reset_n  in  1  asynchronous active-low reset.
REQ-004 SHALL have ports: en_i  in  1  loop enable, level.
REQ-005 SHALL have ports: iq_val  in  1  input sample valid.
REQ-006 SHALL have ports: e_in_i  in  WE signed  timing error from the TED.
REQ-007 SHALL have ports: e_valid_i  in  1  e_in_i qualifier, single-cycle pulse.
REQ-008 SHALL have ports: adj_i  in  2  slip request (01 advance, 11 retard, 00/10 none).
REQ-009 SHALL have ports: adj_val_i  in  1  adj_i qualifier.
REQ-010 SHALL have ports: sym_valid_o  out  1  symbol strobe level, qualified downstream by iq_val.
REQ-011 SHALL have ports: gain_sel_o  out  1  loop-filter gain select (0 acquisition, 1 tracking).
REQ-012 SHALL have ports: state_o  out  2  IDLE=00, FILL=01, ACQ=10, TRACK=11.
REQ-013 SHALL have ports: locked_o  out  1  high in TRACK.
REQ-014 SHALL have ports: slip_ovf_o  out  1  sticky; set when an adjustment is dropped.

Function
REQ-015 SHALL use a registered FSM (IDLE, FILL, ACQ, TRACK) with state_o equal to the state register.
REQ-016 SHALL go IDLE->FILL on the first clock with en_i=1, clearing the fill counter.
REQ-017 SHALL, in FILL, count iq_val cycles and enter ACQ on the iq_val that brings the count to FILL_LEN, with phase_cnt loaded to 0.
REQ-018 SHALL, when en_i=0 in any state, enter IDLE the next clock and clear phase_cnt, good/bad counters and any pending adjustment; en_i has priority over all other events.
REQ-019 SHALL, in ACQ/TRACK, advance phase_cnt by one per iq_val and wrap to 0 after terminal value T, where T=OSF-1 nominal, OSF-2 with advance pending, OSF with retard pending.
REQ-020 SHALL consume a pending adjustment at the wrap it affects; exactly one symbol period is shortened or lengthened by one sample.
REQ-021 SHALL hold at most one pending adjustment; adj_val_i while one is pending SHALL be dropped and set slip_ovf_o; codes 00/10 SHALL be ignored and never set slip_ovf_o.
REQ-022 SHALL, for adj_val_i coinciding with a wrap cycle, apply that request to the following period.
REQ-023 SHALL drive sym_valid_o=1 exactly when state is ACQ/TRACK and phase_cnt==0, as a registered output with no combinational input path.
REQ-024 SHALL compute |e_in_i| with the most-negative value saturated to 2^(WE-1)-1; a symbol is "good" when |e| < LOCK_THR.
REQ-025 SHALL update counters only on e_valid_i in ACQ/TRACK; a good symbol increments good_cnt and clears bad_cnt, a bad symbol increments bad_cnt and clears good_cnt; both counters saturate.
REQ-026 SHALL go ACQ->TRACK on the e_valid_i making good_cnt==LOCK_CNT, clearing both counters.
REQ-027 SHALL go TRACK->ACQ on the e_valid_i making bad_cnt==UNLOCK_CNT, clearing both counters; phase_cnt SHALL continue uninterrupted.
REQ-028 SHALL drive gain_sel_o and locked_o =1 only in TRACK, updating in the same clock as state_o.
REQ-029 SHALL clear slip_ovf_o only on reset or on the IDLE->FILL transition.
REQ-030 SHALL ignore e_valid_i and adj_val_i in IDLE/FILL.

Reset
REQ-031 SHALL, while reset_n=0, asynchronously force state IDLE, all counters 0, no pending adjustment, and all outputs 0 (sym_valid_o, gain_sel_o, locked_o, slip_ovf_o, state_o=00).
REQ-032 SHALL leave IDLE no earlier than the first rising clk edge after reset_n deasserts; reset mid-operation behaves identically.

Verification
REQ-033 SHALL cover: reset, en_i=1, continuous iq_val -> state_o 01 for 24 iq_val, then 10; sym_valid_o high every 20th iq_val.
REQ-034 SHALL cover: advance at phase 5 -> next strobe spacing 19 samples, then 20; retard -> 21, then 20.
REQ-035 SHALL cover: second adj_val_i while pending -> dropped, spacing changes by one sample only, slip_ovf_o=1 until next enable.
REQ-036 SHALL cover: 32 errors of magnitude 100 in ACQ -> TRACK, gain_sel_o=1; then 8 errors of -2048 -> ACQ; error 0x20000 treated as bad.
REQ-037 SHALL cover: 31 good, 1 bad, 31 good -> remains ACQ; one more good -> TRACK.
REQ-038 SHALL cover: en_i=0 mid-TRACK -> IDLE next clock, all outputs 0 except slip_ovf_o; reset_n pulse mid-FILL -> immediate IDLE.
